// File: rtl/alu_pkg.sv
// Shared ALU execution-unit types: opcodes, FSM states, result flags.
// Imported by the top and the iterative multiply/divide engine.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'h0,
    OP_OR    = 4'h1,
    OP_ADD   = 4'h2,
    OP_ADDU  = 4'h3,
    OP_BEQ   = 4'h4,
    OP_BNE   = 4'h5,
    OP_SUB   = 4'h6,
    OP_SLT   = 4'h7,
    OP_SLL   = 4'h8,
    OP_SRL   = 4'h9,
    OP_SLTU  = 4'hA,
    OP_SRA   = 4'hB,
    OP_NOR   = 4'hC,
    OP_MULTU = 4'hD,
    OP_DIVU  = 4'hE,
    OP_XOR   = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ITER     = 2'd1,
    ST_WAIT_OUT = 2'd2
  } state_e;

  typedef struct packed {
    logic branch;
    logic taken;
    logic carry;
    logic ovf;
    logic dbz;
  } res_flags_t;

  function automatic logic is_multi(alu_op_e op);
    return (op == OP_MULTU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_iter.sv
// Radix-2 unsigned multiply (shift-add) / divide (restoring).
// One bit per cycle; done marks the final step, lo/hi carry its result.
module mul_div_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH);

  logic             busy_q, busy_d;
  logic             div_q, div_d;
  logic             dbz_q, dbz_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_s, hi_s;
  logic [WIDTH:0]   sum, rem, diff;
  logic             ge, last;

  assign last = (cnt_q == CW'(WIDTH - 1));
  assign done = busy_q && last;
  assign busy = busy_q;
  assign dbz  = dbz_q;
  assign lo   = done ? lo_s : lo_q;
  assign hi   = done ? hi_s : hi_q;

  // One iteration step on the partial {hi, lo} state
  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    rem  = {hi_q, lo_q[WIDTH-1]};
    diff = rem - {1'b0, m_q};
    ge   = (rem >= {1'b0, m_q});
    lo_s = {sum[0], lo_q[WIDTH-1:1]};
    hi_s = sum[WIDTH:1];
    if (div_q) begin
      lo_s = {lo_q[WIDTH-2:0], ge};
      hi_s = ge ? diff[WIDTH-1:0] : rem[WIDTH-1:0];
    end
  end

  // Load operands on start, step while busy, stop on abort
  always_comb begin
    busy_d = busy_q;
    div_d  = div_q;
    dbz_d  = dbz_q;
    cnt_d  = cnt_q;
    m_d    = m_q;
    lo_d   = lo_q;
    hi_d   = hi_q;
    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      div_d  = is_div;
      dbz_d  = is_div && (b == '0);
      m_d    = is_div ? b : a;
      lo_d   = is_div ? a : b;
      hi_d   = '0;
    end else if (busy_q) begin
      lo_d  = lo_s;
      hi_d  = hi_s;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  // Engine state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      dbz_q  <= 1'b0;
      cnt_q  <= '0;
      m_q    <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
    end else begin
      busy_q <= busy_d;
      div_q  <= div_d;
      dbz_q  <= dbz_d;
      cnt_q  <= cnt_d;
      m_q    <= m_d;
      lo_q   <= lo_d;
      hi_q   <= hi_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle ops plus iterative MULTU/DIVU,
// with a one-entry output register drained by the common data bus.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Flush,
  input  logic                     Issue_Valid,
  output logic                     Issue_Ready,
  input  logic [3:0]               ALU_Opcode,
  input  logic [WIDTH-1:0]         Operand1,
  input  logic [WIDTH-1:0]         Operand2,
  input  logic [$clog2(WIDTH)-1:0] Shfamt,
  input  logic [TAG_W-1:0]         Tag_In,
  output logic                     Out_Valid,
  input  logic                     Out_Ready,
  output logic [WIDTH-1:0]         Result,
  output logic [WIDTH-1:0]         Result_Hi,
  output logic [TAG_W-1:0]         Tag_Out,
  output logic                     ALU_Branch,
  output logic                     ALU_Branch_Taken,
  output logic                     Carry_Out,
  output logic                     Overflow,
  output logic                     Div_By_Zero
);

  alu_op_e          op;
  state_e           state_q, state_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] tagp_q, tagp_d;
  res_flags_t       flg_q, flg_d;
  res_flags_t       sc_flg;
  logic [WIDTH-1:0] sc_res, add_b;
  logic [WIDTH:0]   add_full;
  logic             is_md, ld_free, accept, md_start;
  logic             md_busy, md_done, md_dbz;
  logic [WIDTH-1:0] md_lo, md_hi;

  assign op          = alu_op_e'(ALU_Opcode);
  assign is_md       = is_multi(op);
  assign ld_free     = !ov_q || Out_Ready;
  assign Issue_Ready = (state_q == ST_IDLE) && !md_busy
                       && ld_free && !Flush;
  assign accept      = Issue_Valid && Issue_Ready;
  assign md_start    = accept && is_md;

  assign Out_Valid        = ov_q;
  assign Result           = res_q;
  assign Result_Hi        = hi_q;
  assign Tag_Out          = tag_q;
  assign ALU_Branch       = flg_q.branch;
  assign ALU_Branch_Taken = flg_q.taken;
  assign Carry_Out        = flg_q.carry;
  assign Overflow         = flg_q.ovf;
  assign Div_By_Zero      = flg_q.dbz;

  mul_div_iter #(
    .WIDTH (WIDTH)
  ) u_md (
    .clk    (Clk),
    .rst    (Reset),
    .start  (md_start),
    .abort  (Flush),
    .is_div (op == OP_DIVU),
    .a      (Operand1),
    .b      (Operand2),
    .busy   (md_busy),
    .done   (md_done),
    .dbz    (md_dbz),
    .lo     (md_lo),
    .hi     (md_hi)
  );

  // Single-cycle result and flags; SUB reuses the adder as A + ~B + 1
  always_comb begin
    add_b    = (op == OP_SUB) ? ~Operand2 : Operand2;
    add_full = {1'b0, Operand1} + {1'b0, add_b}
             + {{WIDTH{1'b0}}, op == OP_SUB};
    sc_res   = '0;
    sc_flg   = '0;
    unique case (op)
      OP_AND:  sc_res = Operand1 & Operand2;
      OP_OR:   sc_res = Operand1 | Operand2;
      OP_XOR:  sc_res = Operand1 ^ Operand2;
      OP_NOR:  sc_res = ~(Operand1 | Operand2);
      OP_ADD, OP_SUB: begin
        sc_res       = add_full[WIDTH-1:0];
        sc_flg.carry = add_full[WIDTH];
        sc_flg.ovf   = (Operand1[WIDTH-1] == add_b[WIDTH-1])
                    && (add_full[WIDTH-1] != Operand1[WIDTH-1]);
      end
      OP_ADDU: begin
        sc_res       = add_full[WIDTH-1:0];
        sc_flg.carry = add_full[WIDTH];
      end
      OP_BEQ: begin
        sc_flg.branch = 1'b1;
        sc_flg.taken  = (Operand1 == Operand2);
      end
      OP_BNE: begin
        sc_flg.branch = 1'b1;
        sc_flg.taken  = (Operand1 != Operand2);
      end
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}},
                         $signed(Operand1) < $signed(Operand2)};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, Operand1 < Operand2};
      OP_SLL:  sc_res = Operand1 << Shfamt;
      OP_SRL:  sc_res = Operand1 >> Shfamt;
      OP_SRA:  sc_res = $signed(Operand1) >>> Shfamt;
      default: sc_res = '0;
    endcase
  end

  // Issue, completion and drain control; Flush overrides everything
  always_comb begin
    state_d = state_q;
    ov_d    = ov_q && !Out_Ready;
    res_d   = res_q;
    hi_d    = hi_q;
    tag_d   = tag_q;
    tagp_d  = tagp_q;
    flg_d   = flg_q;
    if (Flush) begin
      state_d = ST_IDLE;
      ov_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept && is_md) begin
            state_d = ST_ITER;
            tagp_d  = Tag_In;
          end else if (accept) begin
            ov_d  = 1'b1;
            res_d = sc_res;
            hi_d  = '0;
            tag_d = Tag_In;
            flg_d = sc_flg;
          end
        end
        ST_ITER, ST_WAIT_OUT: begin
          if ((md_done || state_q == ST_WAIT_OUT) && ld_free) begin
            state_d   = ST_IDLE;
            ov_d      = 1'b1;
            res_d     = md_lo;
            hi_d      = md_hi;
            tag_d     = tagp_q;
            flg_d     = '0;
            flg_d.dbz = md_dbz;
          end else if (md_done) begin
            state_d = ST_WAIT_OUT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control and output registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      ov_q    <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      tag_q   <= '0;
      tagp_q  <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      ov_q    <= ov_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      tag_q   <= tag_d;
      tagp_q  <= tagp_d;
      flg_q   <= flg_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed corner cases followed by
// randomized traffic scored against an arithmetic reference model.
module tb_alu_exec_unit;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] hi;
    logic [4:0]  tag;
    logic        br;
    logic        tk;
    logic        c;
    logic        v;
    logic        dz;
  } exp_t;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
  localparam int     N    = 150;

  logic        Clk, Reset, Flush, Issue_Valid, Issue_Ready;
  logic [3:0]  ALU_Opcode;
  logic [31:0] Operand1, Operand2;
  logic [4:0]  Shfamt, Tag_In;
  logic        Out_Valid, Out_Ready;
  logic [31:0] Result, Result_Hi;
  logic [4:0]  Tag_Out;
  logic        ALU_Branch, ALU_Branch_Taken;
  logic        Carry_Out, Overflow, Div_By_Zero;

  int   checks = 0;
  int   errors = 0;
  int   issued, cyc_n, n;
  logic seen;
  exp_t e;
  exp_t q[$];

  alu_exec_unit #(
    .WIDTH (32),
    .TAG_W (5)
  ) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .Flush            (Flush),
    .Issue_Valid      (Issue_Valid),
    .Issue_Ready      (Issue_Ready),
    .ALU_Opcode       (ALU_Opcode),
    .Operand1         (Operand1),
    .Operand2         (Operand2),
    .Shfamt           (Shfamt),
    .Tag_In           (Tag_In),
    .Out_Valid        (Out_Valid),
    .Out_Ready        (Out_Ready),
    .Result           (Result),
    .Result_Hi        (Result_Hi),
    .Tag_Out          (Tag_Out),
    .ALU_Branch       (ALU_Branch),
    .ALU_Branch_Taken (ALU_Branch_Taken),
    .Carry_Out        (Carry_Out),
    .Overflow         (Overflow),
    .Div_By_Zero      (Div_By_Zero)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [127:0] o,
                     input logic [127:0] x);
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, o, x);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  function automatic exp_t obs();
    return {Result, Result_Hi, Tag_Out, ALU_Branch, ALU_Branch_Taken,
            Carry_Out, Overflow, Div_By_Zero};
  endfunction

  function automatic exp_t model(input logic [3:0] o,
                                 input logic [31:0] x, input logic [31:0] y,
                                 input logic [4:0] s, input logic [4:0] t);
    exp_t   r;
    longint sv;
    logic [32:0] u;
    logic [63:0] p;
    r     = '0;
    r.tag = t;
    case (o)
      4'h0: r.res = x & y;
      4'h1: r.res = x | y;
      4'h2: begin
        u     = {1'b0, x} + {1'b0, y};
        r.res = u[31:0];
        r.c   = u[32];
        sv    = longint'($signed(x)) + longint'($signed(y));
        r.v   = (sv > SMAX) || (sv < SMIN);
      end
      4'h3: begin
        u     = {1'b0, x} + {1'b0, y};
        r.res = u[31:0];
        r.c   = u[32];
      end
      4'h4: begin r.br = 1'b1; r.tk = (x == y); end
      4'h5: begin r.br = 1'b1; r.tk = (x != y); end
      4'h6: begin
        r.res = x - y;
        r.c   = (x >= y);
        sv    = longint'($signed(x)) - longint'($signed(y));
        r.v   = (sv > SMAX) || (sv < SMIN);
      end
      4'h7: r.res = 32'($signed(x) < $signed(y));
      4'h8: r.res = x << s;
      4'h9: r.res = x >> s;
      4'hA: r.res = 32'(x < y);
      4'hB: r.res = $signed(x) >>> s;
      4'hC: r.res = ~(x | y);
      4'hD: begin
        p     = 64'(x) * 64'(y);
        r.res = p[31:0];
        r.hi  = p[63:32];
      end
      4'hE: begin
        if (y == 0) begin
          r.res = 32'hFFFF_FFFF;
          r.hi  = x;
          r.dz  = 1'b1;
        end else begin
          r.res = x / y;
          r.hi  = x % y;
        end
      end
      default: r.res = x ^ y;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 9));
      default: return $urandom();
    endcase
  endfunction

  task automatic run_op(input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] s,
                        input logic [4:0] t, input int lat, input string nm);
    exp_t r;
    int   k;
    logic rb;
    r           = model(o, x, y, s, t);
    Issue_Valid = 1'b1;
    ALU_Opcode  = o;
    Operand1    = x;
    Operand2    = y;
    Shfamt      = s;
    Tag_In      = t;
    Out_Ready   = 1'b1;
    #1;
    chk({nm, "_rdy"}, 128'(Issue_Ready), 128'(1));
    cyc();
    Issue_Valid = 1'b0;
    k  = 1;
    rb = 1'b0;
    while (!Out_Valid && k < 100) begin
      if (Issue_Ready) rb = 1'b1;
      cyc();
      k++;
    end
    if (lat > 1) chk({nm, "_busy"}, 128'(rb), 128'(0));
    chk({nm, "_lat"}, 128'(k), 128'(lat));
    chk({nm, "_res"}, 128'(obs()), 128'(r));
  endtask

  initial begin
    Reset       = 1'b1;
    Flush       = 1'b0;
    Issue_Valid = 1'b0;
    ALU_Opcode  = '0;
    Operand1    = '0;
    Operand2    = '0;
    Shfamt      = '0;
    Tag_In      = '0;
    Out_Ready   = 1'b0;
    repeat (2) cyc();
    chk("reset", 128'({Out_Valid, obs()}), 128'(0));
    Reset = 1'b0;
    cyc();

    run_op(4'h2, 32'h7FFF_FFFF, 32'h1, 5'd0, 5'h13, 1, "add");
    chk("add_lit", 128'({Result, Overflow, Carry_Out, Tag_Out}),
        128'({32'h8000_0000, 1'b1, 1'b0, 5'h13}));

    run_op(4'hD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'h07, 33, "mul");
    chk("mul_lit", 128'({Result_Hi, Result}),
        128'({32'hFFFF_FFFE, 32'h1}));

    run_op(4'hE, 32'd100, 32'd7, 5'd0, 5'h08, 33, "div");
    chk("div_lit", 128'({Result, Result_Hi}), 128'({32'd14, 32'd2}));

    run_op(4'hE, 32'd5, 32'd0, 5'd0, 5'h09, 33, "div0");
    chk("div0_lit", 128'({Result, Result_Hi, Div_By_Zero}),
        128'({32'hFFFF_FFFF, 32'd5, 1'b1}));

    run_op(4'hB, 32'h8000_00F0, 32'd0, 5'd4, 5'h0A, 1, "sra");
    run_op(4'h5, 32'd3, 32'd3, 5'd0, 5'h0B, 1, "bne");
    run_op(4'h6, 32'h8000_0000, 32'd1, 5'd0, 5'h0C, 1, "sub");

    run_op(4'h7, 32'hFFFF_FFFF, 32'h1, 5'd0, 5'h04, 1, "slt");
    e           = model(4'h7, 32'hFFFF_FFFF, 32'h1, 5'd0, 5'h04);
    Out_Ready   = 1'b0;
    Issue_Valid = 1'b1;
    ALU_Opcode  = 4'h2;
    Operand1    = 32'd3;
    Operand2    = 32'd4;
    Tag_In      = 5'h09;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_res", 128'({Out_Valid, obs()}), 128'({1'b1, e}));
      chk("stall_rdy", 128'(Issue_Ready), 128'(0));
      cyc();
    end
    Out_Ready = 1'b1;
    #1;
    chk("resume_rdy", 128'(Issue_Ready), 128'(1));
    cyc();
    Issue_Valid = 1'b0;
    chk("resume_res", 128'({Out_Valid, obs()}),
        128'({1'b1, model(4'h2, 32'd3, 32'd4, 5'd0, 5'h09)}));

    Issue_Valid = 1'b1;
    ALU_Opcode  = 4'hE;
    Operand1    = 32'd1000;
    Operand2    = 32'd3;
    Tag_In      = 5'h11;
    cyc();
    Issue_Valid = 1'b0;
    repeat (9) cyc();
    Flush = 1'b1;
    #1;
    chk("flush_rdy0", 128'(Issue_Ready), 128'(0));
    cyc();
    Flush = 1'b0;
    #1;
    chk("flush_rdy1", 128'({Issue_Ready, Out_Valid}), 128'(2'b10));
    seen = 1'b0;
    repeat (40) begin
      cyc();
      seen = seen | Out_Valid;
    end
    chk("flush_noval", 128'(seen), 128'(0));

    run_op(4'h2, 32'hFFFF_FFFF, 32'd2, 5'd0, 5'h1E, 1, "addc");
    Issue_Valid = 1'b1;
    ALU_Opcode  = 4'hD;
    Operand1    = 32'd1234;
    Operand2    = 32'd5678;
    Tag_In      = 5'h05;
    cyc();
    Issue_Valid = 1'b0;
    repeat (5) cyc();
    #2;
    Reset = 1'b1;
    #1;
    chk("rst_mid", 128'({Out_Valid, obs()}), 128'(0));
    cyc();
    Reset = 1'b0;
    seen  = 1'b0;
    repeat (40) begin
      cyc();
      seen = seen | Out_Valid;
    end
    chk("rst_noval", 128'(seen), 128'(0));

    issued = 0;
    cyc_n  = 0;
    while ((issued < N || q.size() != 0) && cyc_n < 20000) begin
      Issue_Valid = (issued < N) && ($urandom_range(0, 3) != 0);
      ALU_Opcode  = 4'($urandom_range(0, 15));
      if ((ALU_Opcode == 4'hD || ALU_Opcode == 4'hE)
          && $urandom_range(0, 2) != 0)
        ALU_Opcode = 4'($urandom_range(0, 12));
      Operand1  = pick();
      Operand2  = pick();
      Shfamt    = 5'($urandom_range(0, 31));
      Tag_In    = 5'($urandom_range(0, 31));
      Out_Ready = ($urandom_range(0, 3) != 0);
      Flush     = ($urandom_range(0, 40) == 0);
      #1;
      if (Flush) begin
        q.delete();
      end else begin
        if (Out_Valid && Out_Ready) begin
          if (q.size() == 0) begin
            chk("rnd_spur", 128'(Out_Valid), 128'(0));
          end else begin
            e = q.pop_front();
            chk("rnd", 128'(obs()), 128'(e));
          end
        end
        if (Issue_Valid && Issue_Ready) begin
          q.push_back(model(ALU_Opcode, Operand1, Operand2,
                            Shfamt, Tag_In));
          issued++;
        end
      end
      cyc();
      cyc_n++;
    end
    Flush       = 1'b0;
    Issue_Valid = 1'b0;
    chk("rnd_issued", 128'(issued), 128'(N));
    chk("rnd_drain", 128'(q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, 32, operand/result width in bits (>=8, even).
REQ-002 SHALL have parameter TAG_W, 5, reservation-station tag width.
REQ-003 SHALL have port Clk  in  1  single rising-edge clock.
REQ-004 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port Flush  in  1  synchronous kill of in-flight and held results.
REQ-006 SHALL have port Issue_Valid  in  1  operation offered this cycle.
REQ-007 SHALL have port Issue_Ready  out  1  unit accepts an operation this cycle.
REQ-008 SHALL have port ALU_Opcode  in  4  operation select.
REQ-009 SHALL have port Operand1  in  WIDTH  first operand.
REQ-010 SHALL have port Operand2  in  WIDTH  second operand.
REQ-011 SHALL have port Shfamt  in  $clog2(WIDTH)  shift amount.
REQ-012 SHALL have port Tag_In  in  TAG_W  issuing tag.
REQ-013 SHALL have port Out_Valid  out  1  result registers hold a valid result.
REQ-014 SHALL have port Out_Ready  in  1  common data bus consumes the result.
REQ-015 SHALL have port Result  out  WIDTH  result, product low half, or quotient.
REQ-016 SHALL have port Result_Hi  out  WIDTH  product high half or remainder; zero otherwise.
REQ-017 SHALL have port Tag_Out  out  TAG_W  tag of the held result.
REQ-018 SHALL have ports ALU_Branch, ALU_Branch_Taken, Carry_Out, Overflow, Div_By_Zero  out  1 each  status of the held result.

Function
REQ-019 SHALL decode opcodes AND 0, OR 1, ADD 2, ADDU 3, BEQ 4, BNE 5, SUB 6, SLT 7, SLL 8, SRL 9, SLTU A, SRA B, NOR C, MULTU D, DIVU E, XOR F.
REQ-020 SHALL accept an operation on a rising edge where Issue_Valid && Issue_Ready && !Flush.
REQ-021 SHALL drive Issue_Ready = (state == IDLE) && (!Out_Valid || Out_Ready) && !Flush.
REQ-022 SHALL register single-cycle ops (all except D, E): Out_Valid high the cycle after acceptance, latency 1.
REQ-023 SHALL compute ADD/SUB/ADDU over WIDTH bits; Carry_Out = carry out of MSB (SUB: A + ~B + 1); Overflow = signed overflow for ADD/SUB only; all flags 0 for other ops.
REQ-024 SHALL compute SLT signed and SLTU unsigned, result 1 or 0; SRA sign-fills; shifts by Shfamt only.
REQ-025 SHALL for BEQ/BNE set ALU_Branch = 1, ALU_Branch_Taken = (Op1 == Op2) or (Op1 != Op2), Result = 0.
REQ-026 SHALL implement MULTU and DIVU iteratively with one bit per cycle, states IDLE -> ITER (WIDTH cycles) -> WAIT_OUT -> IDLE.
REQ-027 SHALL load results into output registers on the last ITER cycle if the registers are empty or being drained, giving Out_Valid WIDTH+1 cycles after acceptance; otherwise SHALL enter WAIT_OUT and load on the first cycle they free.
REQ-028 SHALL produce {Result_Hi, Result} = full 2*WIDTH-bit unsigned product for MULTU.
REQ-029 SHALL produce quotient in Result and remainder in Result_Hi for DIVU; divisor 0 gives Result = all ones, Result_Hi = Operand1, Div_By_Zero = 1, same latency.
REQ-030 SHALL hold Result, Result_Hi, Tag_Out and all flags stable while Out_Valid && !Out_Ready.
REQ-031 SHALL clear Out_Valid on a cycle with Out_Ready unless a new result loads that same edge.
REQ-032 SHALL on Flush clear Out_Valid, abandon ITER/WAIT_OUT to IDLE, ignore Issue_Valid; Flush takes precedence over issue, completion and Out_Ready.

Reset
REQ-033 SHALL on Reset asynchronously set state IDLE, Out_Valid 0, Result 0, Result_Hi 0, Tag_Out 0, all flags 0, iteration counter 0.
REQ-034 SHALL abort any multi-cycle operation in progress when Reset asserts; no result is produced for it.

Structure
REQ-035 SHALL take opcode constants, state enum and result-bundle struct from shared package alu_pkg.
REQ-036 SHALL place the iterative multiplier/divider in sub-module mul_div_iter (start, busy, done handshake).

Verification
REQ-037 SHALL verify ADD 0x7FFFFFFF + 1 -> Out_Valid next cycle, Result 0x80000000, Overflow 1, Carry_Out 0, Tag_Out = Tag_In.
REQ-038 SHALL verify MULTU 0xFFFFFFFF * 0xFFFFFFFF -> after 33 cycles Result 0x00000001, Result_Hi 0xFFFFFFFE, Issue_Ready 0 during ITER.
REQ-039 SHALL verify DIVU 100 / 7 -> Result 14, Result_Hi 2; DIVU 5 / 0 -> Result 0xFFFFFFFF, Result_Hi 5, Div_By_Zero 1.
REQ-040 SHALL verify Out_Ready held 0 for 3 cycles after SLT 0xFFFFFFFF, 1 -> Result 1 stable, Issue_Ready 0, back-to-back issue resumes when Out_Ready rises.
REQ-041 SHALL verify Flush at ITER cycle 10 of DIVU -> no Out_Valid, Issue_Ready 1 next cycle; Reset mid-MULTU -> all outputs 0 immediately.
